// File: rtl/fabric_tag_arbiter_if.sv
// Handshake bundle for fabric_tag_arbiter: NUM_IN untagged input streams and one
// tagged output stream. The arbiter takes the slave side, the stream environment the master.
interface fabric_tag_arbiter_if #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
);
    logic [NUM_IN-1:0]               in_valid;
    logic [NUM_IN-1:0]               in_ready;
    logic [NUM_IN*DATA_WIDTH-1:0]    in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_WIDTH+TAG_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fabric_tag_arbiter.sv
// Round-robin arbiter sharing one registered, tagged output among NUM_IN input streams.
// Each winner's payload is prefixed with its configured tag from cfg_data.
module fabric_tag_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_IN*(TAG_WIDTH+1)-1:0] cfg_data,
    fabric_tag_arbiter_if.slave             bus
);
    localparam int CONFIG_WIDTH = NUM_IN * (TAG_WIDTH + 1);
    localparam int SLOT_W       = TAG_WIDTH + 1;
    localparam int PTR_W        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int OUT_W        = DATA_WIDTH + TAG_WIDTH;

    generate
        if (NUM_IN < 2) begin : g_bad_num_in
            $fatal(1, "COMP_TAG_ARB_NUM_IN: NUM_IN must be >= 2");
        end
        if (DATA_WIDTH < 1) begin : g_bad_data_width
            $fatal(1, "COMP_TAG_ARB_DATA_WIDTH: DATA_WIDTH must be >= 1");
        end
        if (TAG_WIDTH < 1) begin : g_bad_tag_width
            $fatal(1, "COMP_TAG_ARB_TAG_WIDTH: TAG_WIDTH must be >= 1");
        end
        if (CONFIG_WIDTH != NUM_IN * SLOT_W) begin : g_bad_cfg_width
            $fatal(1, "COMP_TAG_ARB_CONFIG_WIDTH: inconsistent configuration width");
        end
    endgenerate

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [NUM_IN-1:0] eligible;
    logic [NUM_IN-1:0] in_ready;
    logic              any_eligible;
    logic [PTR_W-1:0]  grant;
    logic              load_en;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            eligible[i] = bus.in_valid[i] && cfg_data[i*SLOT_W + TAG_WIDTH];
        end
    end

    // Scan from the farthest offset down so the eligible input nearest rr_ptr wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        any_eligible = 1'b0;
        grant        = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr_q) + k) % NUM_IN]) begin
                any_eligible = 1'b1;
                grant        = PTR_W'((int'(rr_ptr_q) + k) % NUM_IN);
            end
        end
    end

    always_comb begin
        load_en     = !out_valid_q || bus.out_ready;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready    = '0;
        if (load_en) begin
            out_valid_d = any_eligible;
            if (any_eligible) begin
                out_data_d = {cfg_data[int'(grant)*SLOT_W +: TAG_WIDTH],
                              bus.in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH]};
                rr_ptr_d   = (int'(grant) == NUM_IN - 1) ? '0 : grant + PTR_W'(1);
                // Gated by rst_n so no upstream sees a handshake while reset is held.
                in_ready[grant] = rst_n;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_fabric_tag_arbiter.sv
// Self-checking bench for fabric_tag_arbiter: directed scenarios followed by random
// traffic, all compared against a distance-based round-robin reference model.
module tb_fabric_tag_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int OW = DW + TW;

    logic            clk;
    logic            rst_n;
    logic [N*(TW+1)-1:0] cfg;

    fabric_tag_arbiter_if #(.NUM_IN(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    fabric_tag_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_data (cfg),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stimulus state, kept at the level of "per-input" values.
    logic [N-1:0]  cur_valid;
    logic          cur_ordy;
    logic [DW-1:0] din     [N];
    logic          cfg_en  [N];
    logic [TW-1:0] cfg_tag [N];

    // Reference model: held output word and the index that has first claim.
    logic          m_valid;
    logic [OW-1:0] m_data;
    int            m_rr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            cfg[i*(TW+1) +: TW+1] = {cfg_en[i], cfg_tag[i]};
            bus.in_data[i*DW +: DW] = din[i];
        end
        bus.in_valid  = cur_valid;
        bus.out_ready = cur_ordy;
    endtask

    task automatic default_cfg();
        for (int i = 0; i < N; i++) begin
            cfg_en[i]  = 1'b1;
            cfg_tag[i] = TW'(i);
        end
    endtask

    // Winner = eligible input at the smallest forward distance from the model pointer.
    function automatic int pick();
        int best      = -1;
        int best_dist = N;
        for (int i = 0; i < N; i++) begin
            if (cur_valid[i] && cfg_en[i]) begin
                int d;
                d = (i - m_rr + N) % N;
                if (d < best_dist) begin
                    best_dist = d;
                    best      = i;
                end
            end
        end
        return best;
    endfunction

    task automatic tick();
        logic          load;
        int            g;
        logic [N-1:0]  exp_rdy;
        logic [OW-1:0] nxt_data;
        apply();
        #1;
        load    = !m_valid || cur_ordy;
        g       = pick();
        exp_rdy = '0;
        if (load && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        nxt_data = (g >= 0) ? {cfg_tag[g], din[g]} : '0;
        @(posedge clk);
        #1;
        if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = nxt_data;
                m_rr    = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        check("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (m_valid) check("out_data", 64'(bus.out_data), 64'(m_data));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n   = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
        m_rr    = 0;
    endtask

    initial begin
        logic [OW-1:0] held;
        rst_n = 1'b0;
        default_cfg();
        for (int i = 0; i < N; i++) din[i] = DW'(32'h1000_0000 * i + 32'h11);
        cur_valid = 4'b1111;
        cur_ordy  = 1'b1;
        apply();
        m_valid = 1'b0;
        m_data  = '0;
        m_rr    = 0;

        // Reset state with every input requesting.
        #12;
        check("init_out_valid", 64'(bus.out_valid), 64'd0);
        check("init_out_data", 64'(bus.out_data), 64'd0);
        check("init_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;

        // Reset while a word is held drops it immediately.
        cur_valid = 4'b0001;
        cur_ordy  = 1'b0;
        tick();
        check("held_before_rst", 64'(bus.out_valid), 64'd1);
        cur_valid = 4'b1111;
        apply();
        do_reset();

        // Single input, tag_2 = 2.
        cur_valid = 4'b0100;
        cur_ordy  = 1'b1;
        din[2]    = 32'h0000_00A5;
        tick();
        check("single_word", 64'(bus.out_data), 64'h2_0000_00A5);
        cur_valid = 4'b0000;
        tick();
        check("single_idle", 64'(bus.out_valid), 64'd0);

        // Fairness: all valid, one word per cycle, tags 0,1,2,3,0.
        do_reset();
        cur_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) din[i] = $urandom;
            tick();
            check("fair_tag", 64'(bus.out_data[OW-1 -: TW]), 64'(k % N));
        end

        // Backpressure: held stable for 5 cycles, tag change during the hold.
        do_reset();
        cur_valid = 4'b0001;
        din[0]    = 32'hCAFE_0000;
        tick();
        held      = {4'h0, 32'hCAFE_0000};
        cur_valid = 4'b1111;
        cur_ordy  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) for (int i = 0; i < N; i++) cfg_tag[i] = 4'hF;
            tick();
            check("bp_stable", 64'(bus.out_data), 64'(held));
        end
        cur_ordy = 1'b1;
        din[1]   = 32'h0BAD_F00D;
        tick();
        check("bp_release", 64'(bus.out_data), 64'h F_0BAD_F00D);
        default_cfg();

        // Disabled input 1: grants alternate 0,2.
        do_reset();
        cfg_en[1] = 1'b0;
        cur_valid = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("dis_tag", 64'(bus.out_data[OW-1 -: TW]), 64'((k % 2) * 2));
        end
        default_cfg();

        // Wrap: pointer at 3, single word from input 3, then idle, then pointer is 0.
        do_reset();
        cur_valid = 4'b0100;
        tick();
        cur_valid = 4'b1000;
        tick();
        check("wrap_tag", 64'(bus.out_data[OW-1 -: TW]), 64'd3);
        cur_valid = 4'b0000;
        tick();
        check("wrap_idle", 64'(bus.out_valid), 64'd0);
        cur_valid = 4'b1111;
        tick();
        check("wrap_ptr0", 64'(bus.out_data[OW-1 -: TW]), 64'd0);

        // Random traffic with occasional configuration changes.
        for (int c = 0; c < 400; c++) begin
            cur_valid = N'($urandom);
            cur_ordy  = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) din[i] = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                for (int i = 0; i < N; i++) begin
                    cfg_en[i]  = ($urandom_range(0, 3) != 0);
                    cfg_tag[i] = TW'($urandom);
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
